// File: rtl/imm_gen_pipe.sv
//==============================================================================
// imm_gen_pipe
//------------------------------------------------------------------------------
// Registered immediate generator for the NPC decode stage.
//
// An instruction word, a format select and a sideband tag (normally the PC)
// are accepted via a valid/ready handshake. The XLEN-wide immediate is
// computed at enqueue time and stored with the tag and an illegal-select
// flag in a 2-entry FIFO. Decode can then stall without losing work.
// The instruction word itself is not buffered.
//
// Parameters
//   XLEN   datapath width, 32 or 64
//   TAG_W  width of the sideband tag
//   SEL_W  width of the format select
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     upstream entry valid
//   in_ready     an entry can be accepted this cycle (count < 2)
//   in_inst      instruction word
//   in_sel       immediate format select
//   in_tag       sideband tag
//   flush        synchronous discard of all buffered entries
//   out_valid    head entry valid
//   out_ready    downstream accepts the head entry
//   out_imm      immediate of the head entry (0 when empty)
//   out_tag      tag of the head entry (0 when empty)
//   out_illegal  head entry had an undefined select (0 when empty)
//==============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    // Format select encoding
    localparam logic [SEL_W-1:0] SEL_R  = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_I  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_IM = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_IJ = SEL_W'(3);
    localparam logic [SEL_W-1:0] SEL_S  = SEL_W'(4);
    localparam logic [SEL_W-1:0] SEL_B  = SEL_W'(5);
    localparam logic [SEL_W-1:0] SEL_J  = SEL_W'(6);
    localparam logic [SEL_W-1:0] SEL_UA = SEL_W'(7);
    localparam logic [SEL_W-1:0] SEL_UL = SEL_W'(8);
    localparam logic [SEL_W-1:0] SEL_E  = SEL_W'(9);
    localparam logic [SEL_W-1:0] SEL_SH = SEL_W'(10);
    localparam logic [SEL_W-1:0] SEL_Z  = SEL_W'(11);

    // Immediate is always built at 64 bits and truncated to XLEN. This keeps
    // every sign-extension replication width positive for both XLEN values.
    logic [63:0]     imm_wide;
    logic            new_illegal;
    logic [XLEN-1:0] new_imm;

    // FIFO state: two slots, 1-bit circular pointers, occupancy 0..2
    logic [XLEN-1:0]  imm_q [2];
    logic [TAG_W-1:0] tag_q [2];
    logic             ill_q [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    logic push;
    logic pop;

    // Opcode bits [6:0] never contribute to an immediate, and for XLEN=32 the
    // upper half of imm_wide is discarded. They are gathered here explicitly.
    logic unused_bits;
    assign unused_bits = &{1'b0, in_inst[6:0], imm_wide};

    // Immediate decode for the incoming instruction
    always_comb begin
        imm_wide    = 64'd0;
        new_illegal = 1'b0;
        case (in_sel)
            SEL_R, SEL_E: begin
                imm_wide = 64'd0;
            end
            SEL_I, SEL_IM, SEL_IJ: begin
                imm_wide = {{52{in_inst[31]}}, in_inst[31:20]};
            end
            SEL_S: begin
                imm_wide = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            SEL_B: begin
                imm_wide = {{51{in_inst[31]}}, in_inst[31], in_inst[7],
                            in_inst[30:25], in_inst[11:8], 1'b0};
            end
            SEL_J: begin
                imm_wide = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12],
                            in_inst[20], in_inst[30:21], 1'b0};
            end
            SEL_UA, SEL_UL: begin
                imm_wide = {{32{in_inst[31]}}, in_inst[31:12], 12'd0};
            end
            SEL_SH: begin
                // RV64 shift amounts use a 6-bit shamt, RV32 only 5 bits
                if (XLEN == 64) begin
                    imm_wide = {58'd0, in_inst[25:20]};
                end else begin
                    imm_wide = {59'd0, in_inst[24:20]};
                end
            end
            SEL_Z: begin
                imm_wide = {59'd0, in_inst[19:15]};
            end
            default: begin
                imm_wide    = 64'd0;
                new_illegal = 1'b1;
            end
        endcase
    end

    assign new_imm = imm_wide[XLEN-1:0];

    // Handshake qualifiers. in_ready depends only on registered count. A full
    // FIFO therefore refuses a push even when the head is being popped.
    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // Head presentation; outputs are forced to zero while empty
    assign out_imm     = out_valid ? imm_q[rd_ptr] : '0;
    assign out_tag     = out_valid ? tag_q[rd_ptr] : '0;
    assign out_illegal = out_valid ? ill_q[rd_ptr] : 1'b0;

    // FIFO storage and pointers. Flush only resets occupancy and pointers.
    // Stale slot contents are harmless because outputs are gated by count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                imm_q[i] <= '0;
                tag_q[i] <= '0;
                ill_q[i] <= 1'b0;
            end
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                imm_q[wr_ptr] <= new_imm;
                tag_q[wr_ptr] <= in_tag;
                ill_q[wr_ptr] <= new_illegal;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
//==============================================================================
// tb_imm_gen_pipe
//------------------------------------------------------------------------------
// Drives an XLEN=32 and an XLEN=64 instance of imm_gen_pipe with identical
// stimulus. Both are compared every cycle against a queue-based reference
// model that computes immediates with plain signed arithmetic.
//==============================================================================
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [3:0]  in_sel;
    logic [31:0] in_tag;
    logic        flush;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32, out_tag32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [31:0] out_tag64;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .SEL_W(4)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_inst(in_inst), .in_sel(in_sel), .in_tag(in_tag),
        .flush(flush),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_tag(out_tag32), .out_illegal(out_illegal32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .SEL_W(4)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_inst(in_inst), .in_sel(in_sel), .in_tag(in_tag),
        .flush(flush),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64), .out_illegal(out_illegal64)
    );

    typedef struct {
        logic [63:0] imm32;
        logic [63:0] imm64;
        logic [31:0] tag;
        logic        ill;
    } entry_t;

    entry_t model_q[$];
    int     tests = 0;
    int     fails = 0;

    // Reference immediate from the instruction-set rules, truncated to xlen
    function automatic logic [63:0] refImm(input logic [31:0] inst, input int sel, input int xlen);
        longint v;
        case (sel)
            1, 2, 3: v = longint'($signed(inst[31:20]));
            4:       v = longint'($signed({inst[31:25], inst[11:7]}));
            5:       v = longint'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            6:       v = longint'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            7, 8:    v = longint'($signed(inst[31:12])) * 64'sd4096;
            10:      v = (xlen == 64) ? longint'(inst[25:20]) : longint'(inst[24:20]);
            11:      v = longint'(inst[19:15]);
            default: v = 0;
        endcase
        if (xlen == 32) return {32'd0, v[31:0]};
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Compare both instances against the model's current head and occupancy
    task automatic compareModel();
        entry_t h;
        logic   ev;
        logic   er;
        h  = '{imm32: 64'd0, imm64: 64'd0, tag: 32'd0, ill: 1'b0};
        ev = (model_q.size() > 0);
        er = (model_q.size() < 2);
        if (ev) h = model_q[0];
        checkOutput("in_ready32",  64'(in_ready32),  64'(er));
        checkOutput("out_valid32", 64'(out_valid32), 64'(ev));
        checkOutput("out_imm32",   {32'd0, out_imm32}, h.imm32);
        checkOutput("out_tag32",   64'(out_tag32),   64'(h.tag));
        checkOutput("out_ill32",   64'(out_illegal32), 64'(h.ill));
        checkOutput("in_ready64",  64'(in_ready64),  64'(er));
        checkOutput("out_valid64", 64'(out_valid64), 64'(ev));
        checkOutput("out_imm64",   out_imm64,        h.imm64);
        checkOutput("out_tag64",   64'(out_tag64),   64'(h.tag));
        checkOutput("out_ill64",   64'(out_illegal64), 64'(h.ill));
    endtask

    // One clock cycle: drive inputs at the falling edge, check, advance model
    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [3:0] sel,
                                 input logic [31:0] tag, input logic ordy, input logic fl);
        entry_t e;
        logic   do_push;
        logic   do_pop;
        in_valid  = v;
        in_inst   = inst;
        in_sel    = sel;
        in_tag    = tag;
        out_ready = ordy;
        flush     = fl;
        compareModel();
        do_push = v && (model_q.size() < 2) && !fl;
        do_pop  = (model_q.size() > 0) && ordy && !fl;
        e.imm32 = refImm(inst, int'(sel), 32);
        e.imm64 = refImm(inst, int'(sel), 64);
        e.tag   = tag;
        e.ill   = (sel >= 4'd12);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(e);
        end
        @(negedge clk);
    endtask

    // Push one entry into an empty FIFO, check its immediate, then pop it
    task automatic directedImm(input string name, input logic [31:0] inst, input logic [3:0] sel,
                               input logic [63:0] exp32, input logic [63:0] exp64, input logic exp_ill);
        applyStimulus(1'b1, inst, sel, 32'h100, 1'b0, 1'b0);
        checkOutput({name, "_v"},   64'(out_valid32), 64'd1);
        checkOutput({name, "_32"},  {32'd0, out_imm32}, exp32);
        checkOutput({name, "_64"},  out_imm64, exp64);
        checkOutput({name, "_ill"}, 64'(out_illegal64), 64'(exp_ill));
        applyStimulus(1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0);
        checkOutput({name, "_pop"}, 64'(out_valid32), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_inst   = 32'd0;
        in_sel    = 4'd0;
        in_tag    = 32'd0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        compareModel();
        @(negedge clk);
        rst = 1'b0;

        // Immediate formats from the instruction set
        directedImm("addi_m1", 32'hFFF00093, 4'd1,  64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        directedImm("lui",     32'h800002B7, 4'd8,  64'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        directedImm("slli",    32'h03F01013, 4'd10, 64'h1F,       64'h3F,               1'b0);
        directedImm("beq_m4",  32'hFE000EE3, 4'd5,  64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        directedImm("jal_8",   32'h0080006F, 4'd6,  64'h8,        64'h8,                1'b0);
        directedImm("csrzimm", 32'h000FD073, 4'd11, 64'h1F,       64'h1F,               1'b0);
        directedImm("sw_m4",   32'hFE112E23, 4'd4,  64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        directedImm("illegal", 32'hFFFFFFFF, 4'd13, 64'h0,        64'h0,                1'b1);

        // Backpressure: two entries fill the FIFO, a third is refused
        applyStimulus(1'b1, 32'h00100093, 4'd1, 32'hA, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00200093, 4'd1, 32'hB, 1'b0, 1'b0);
        checkOutput("full_in_ready", 64'(in_ready32), 64'd0);
        applyStimulus(1'b1, 32'h00300093, 4'd1, 32'hC, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("drain_tag_b", 64'(out_tag32), 64'hB);
        applyStimulus(1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("drain_empty", 64'(out_valid64), 64'd0);

        // Simultaneous push and pop at count 1, then flush at count 2
        applyStimulus(1'b1, 32'h00500093, 4'd1, 32'h11, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00600093, 4'd1, 32'h22, 1'b1, 1'b0);
        checkOutput("pp_head_tag", 64'(out_tag64), 64'h22);
        checkOutput("pp_ready", 64'(in_ready64), 64'd1);
        applyStimulus(1'b1, 32'h00700093, 4'd1, 32'h33, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00800093, 4'd1, 32'h44, 1'b0, 1'b1);
        checkOutput("flush_valid", 64'(out_valid32), 64'd0);
        checkOutput("flush_ready", 64'(in_ready32), 64'd1);
        applyStimulus(1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0);

        // Asynchronous reset while full
        applyStimulus(1'b1, 32'hFFF00093, 4'd1, 32'h55, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h800002B7, 4'd8, 32'h66, 1'b0, 1'b0);
        #2;
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        model_q.delete();
        checkOutput("arst_valid", 64'(out_valid64), 64'd0);
        checkOutput("arst_ready", 64'(in_ready64), 64'd1);
        checkOutput("arst_imm",   out_imm64, 64'd0);
        checkOutput("arst_tag",   64'(out_tag32), 64'd0);
        compareModel();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom_range(0, 9) < 7),
                          $urandom,
                          4'($urandom_range(0, 15)),
                          $urandom,
                          ($urandom_range(0, 9) < 5),
                          ($urandom_range(0, 29) == 0));
        end
        compareModel();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
